// File: rtl/vec_pkg.sv
// Shared definitions for the vector issue sequencer: legal function codes,
// FSM state encoding and the funct legality check.
package vec_pkg;

    localparam logic [6:0] VADD = 7'b0000000;
    localparam logic [6:0] VSUB = 7'b0000001;
    localparam logic [6:0] VMUL = 7'b0000010;
    localparam logic [6:0] VLE  = 7'b1000000;
    localparam logic [6:0] VSE  = 7'b0100000;

    // Width of the packed vs1/vs2/vr register fields in a queue entry.
    localparam int REGS_W = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_e;

    function automatic logic is_legal_funct(input logic [6:0] funct);
        return (funct == VADD) || (funct == VSUB) || (funct == VMUL) ||
               (funct == VLE)  || (funct == VSE);
    endfunction

endpackage

// File: rtl/vec_instr_fifo.sv
// In-order instruction queue with push/pop/flush; flush wins over a same-cycle push.
// The caller must only push when not full and only pop when not empty.
module vec_instr_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 47
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    input  logic [DATA_W-1:0]              wdata_i,
    output logic [DATA_W-1:0]              rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap on natural overflow.
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/vector_issue_sequencer.sv
// Vector unit front end: queues core instructions, issues them one at a time
// with start_op/op_done, retires zero-length ops locally and watches for a hung unit.
//
// state | meaning
// IDLE  | no op in flight; pops the queue head when one is present
// ISSUE | one-cycle start pulse to the vector unit
// WAIT  | op in flight; waiting for op_done or the watchdog
module vector_issue_sequencer
    import vec_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int VL_WIDTH       = 25,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  logic [6:0]                         instr_funct,
    input  logic [4:0]                         instr_vs1,
    input  logic [4:0]                         instr_vs2,
    input  logic [4:0]                         instr_vr,
    input  logic [VL_WIDTH-1:0]                instr_vl,
    input  logic                               flush,
    output logic                               vpu_enable,
    output logic                               vpu_start_op,
    output logic [6:0]                         vpu_funct,
    output logic [4:0]                         vpu_vs1,
    output logic [4:0]                         vpu_vs2,
    output logic [4:0]                         vpu_vr,
    output logic [VL_WIDTH-1:0]                vpu_vl,
    input  logic                               vpu_op_done,
    output logic                               busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
    output logic [CNT_WIDTH-1:0]               retired_count,
    output logic                               illegal_op,
    output logic                               timeout_err
);

    localparam int PAY_W = 7 + REGS_W + VL_WIDTH;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    state_e               state_q, state_d;
    logic [PAY_W-1:0]     issue_q, issue_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 timeout_q, timeout_d;
    logic                 illegal_q, illegal_d;

    logic                 fifo_full, fifo_empty;
    logic [PAY_W-1:0]     head;
    logic                 handshake, funct_ok, push, pop;

    assign instr_ready = !rst && !fifo_full;
    assign handshake   = instr_valid && instr_ready;
    assign funct_ok    = is_legal_funct(instr_funct);
    assign push        = handshake && funct_ok && !flush;
    assign pop         = (state_q == IDLE) && !fifo_empty;
    assign illegal_d   = handshake && !funct_ok && !flush;

    vec_instr_fifo #(
        .DEPTH  (QUEUE_DEPTH),
        .DATA_W (PAY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i ({instr_funct, instr_vs1, instr_vs2, instr_vr, instr_vl}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (queue_count)
    );

    always_comb begin
        state_d      = state_q;
        issue_d      = issue_q;
        timer_d      = timer_q;
        retired_d    = retired_q;
        timeout_d    = timeout_q;
        vpu_enable   = 1'b0;
        vpu_start_op = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    // Zero-length ops never reach the unit; issue registers keep the last real op.
                    if (head[VL_WIDTH-1:0] == '0) begin
                        retired_d = retired_q + 1'b1;
                    end else begin
                        issue_d = head;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                vpu_enable   = 1'b1;
                vpu_start_op = 1'b1;
                timer_d      = TW'(TIMEOUT_CYCLES - 1);
                state_d      = WAIT;
            end
            WAIT: begin
                vpu_enable = 1'b1;
                if (vpu_op_done) begin
                    retired_d = retired_q + 1'b1;
                    state_d   = IDLE;
                end else if (timer_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            issue_q   <= '0;
            timer_q   <= '0;
            retired_q <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            issue_q   <= issue_d;
            timer_q   <= timer_d;
            retired_q <= retired_d;
            timeout_q <= timeout_d;
            illegal_q <= illegal_d;
        end
    end

    assign vpu_funct     = issue_q[PAY_W-1 -: 7];
    assign vpu_vs1       = issue_q[VL_WIDTH+14 -: 5];
    assign vpu_vs2       = issue_q[VL_WIDTH+9 -: 5];
    assign vpu_vr        = issue_q[VL_WIDTH+4 -: 5];
    assign vpu_vl        = issue_q[VL_WIDTH-1:0];
    assign busy          = (queue_count != '0) || (state_q != IDLE);
    assign retired_count = retired_q;
    assign illegal_op    = illegal_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Bench for vector_issue_sequencer: directed scenarios plus random traffic,
// all checked each cycle against a queue-based behavioural model.
module tb_vector_issue_sequencer;

    localparam int QD  = 4;
    localparam int VLW = 25;
    localparam int TO  = 64;
    localparam int CW  = 16;

    typedef struct packed {
        logic [6:0]     f;
        logic [4:0]     s1;
        logic [4:0]     s2;
        logic [4:0]     r;
        logic [VLW-1:0] vl;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           instr_valid = 1'b0;
    logic           instr_ready;
    logic [6:0]     instr_funct = '0;
    logic [4:0]     instr_vs1 = '0, instr_vs2 = '0, instr_vr = '0;
    logic [VLW-1:0] instr_vl = '0;
    logic           flush = 1'b0;
    logic           vpu_enable, vpu_start_op;
    logic [6:0]     vpu_funct;
    logic [4:0]     vpu_vs1, vpu_vs2, vpu_vr;
    logic [VLW-1:0] vpu_vl;
    logic           vpu_op_done = 1'b0;
    logic           busy;
    logic [2:0]     queue_count;
    logic [CW-1:0]  retired_count;
    logic           illegal_op, timeout_err;

    int tests = 0;
    int fails = 0;

    // Behavioural model: phase 0 = nothing in flight, 1 = start cycle, 2 = awaiting done.
    ent_t mq[$];
    int   ph = 0;
    int   wcnt = 0;
    int   m_ret = 0;
    bit   m_to = 1'b0;
    bit   m_ill = 1'b0;
    ent_t last = '0;

    always #5 clk = ~clk;

    vector_issue_sequencer #(
        .QUEUE_DEPTH    (QD),
        .VL_WIDTH       (VLW),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_funct   (instr_funct),
        .instr_vs1     (instr_vs1),
        .instr_vs2     (instr_vs2),
        .instr_vr      (instr_vr),
        .instr_vl      (instr_vl),
        .flush         (flush),
        .vpu_enable    (vpu_enable),
        .vpu_start_op  (vpu_start_op),
        .vpu_funct     (vpu_funct),
        .vpu_vs1       (vpu_vs1),
        .vpu_vs2       (vpu_vs2),
        .vpu_vr        (vpu_vr),
        .vpu_vl        (vpu_vl),
        .vpu_op_done   (vpu_op_done),
        .busy          (busy),
        .queue_count   (queue_count),
        .retired_count (retired_count),
        .illegal_op    (illegal_op),
        .timeout_err   (timeout_err)
    );

    function automatic bit legal(input logic [6:0] f);
        return f == 7'h00 || f == 7'h01 || f == 7'h02 || f == 7'h40 || f == 7'h20;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ph = 0; wcnt = 0; m_ret = 0; m_to = 1'b0; m_ill = 1'b0; last = '0;
    endtask

    task automatic check_all();
        logic [15:0] r16;
        r16 = m_ret[15:0];
        chk("queue_count",   32'(queue_count),   32'(mq.size()));
        chk("instr_ready",   32'(instr_ready),   32'(mq.size() < QD));
        chk("busy",          32'(busy),          32'(mq.size() != 0 || ph != 0));
        chk("vpu_start_op",  32'(vpu_start_op),  32'(ph == 1));
        chk("vpu_enable",    32'(vpu_enable),    32'(ph != 0));
        chk("retired_count", 32'(retired_count), 32'(r16));
        chk("illegal_op",    32'(illegal_op),    32'(m_ill));
        chk("timeout_err",   32'(timeout_err),   32'(m_to));
        chk("vpu_funct",     32'(vpu_funct),     32'(last.f));
        chk("vpu_vs1",       32'(vpu_vs1),       32'(last.s1));
        chk("vpu_vs2",       32'(vpu_vs2),       32'(last.s2));
        chk("vpu_vr",        32'(vpu_vr),        32'(last.r));
        chk("vpu_vl",        32'(vpu_vl),        32'(last.vl));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},   32'(instr_ready),   0);
        chk({tag, "_enable"},  32'(vpu_enable),    0);
        chk({tag, "_start"},   32'(vpu_start_op),  0);
        chk({tag, "_fields"},  32'(|{vpu_funct, vpu_vs1, vpu_vs2, vpu_vr, vpu_vl}), 0);
        chk({tag, "_busy"},    32'(busy),          0);
        chk({tag, "_qcount"},  32'(queue_count),   0);
        chk({tag, "_retired"}, 32'(retired_count), 0);
        chk({tag, "_illegal"}, 32'(illegal_op),    0);
        chk({tag, "_timeout"}, 32'(timeout_err),   0);
    endtask

    // Advance the model with the inputs currently applied, clock once, then compare.
    task automatic step();
        ent_t h;
        ent_t c;
        bit   hs;
        c  = '{f: instr_funct, s1: instr_vs1, s2: instr_vs2, r: instr_vr, vl: instr_vl};
        hs = instr_valid && (mq.size() < QD);
        m_ill = hs && !flush && !legal(instr_funct);
        case (ph)
            0: if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.vl == 0) m_ret++;
                else begin
                    last = h;
                    ph = 1;
                end
            end
            1: begin
                ph = 2;
                wcnt = 0;
            end
            default: begin
                if (vpu_op_done) begin
                    m_ret++;
                    ph = 0;
                end else if (wcnt == TO - 1) begin
                    m_to = 1'b1;
                    ph = 0;
                end else wcnt++;
            end
        endcase
        if (flush) mq.delete();
        else if (hs && legal(instr_funct)) mq.push_back(c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [6:0] f, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] r, input logic [VLW-1:0] l);
        instr_valid = v; instr_funct = f; instr_vs1 = a; instr_vs2 = b; instr_vr = r; instr_vl = l;
    endtask

    task automatic run_until_wait(input string tag);
        int n = 0;
        while (ph != 2 && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(vpu_enable), 1);
    endtask

    task automatic done_pulse();
        vpu_op_done = 1'b1;
        step();
        vpu_op_done = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        int sel;
        logic [6:0] lf [5];
        lf[0] = 7'h00; lf[1] = 7'h01; lf[2] = 7'h02; lf[3] = 7'h40; lf[4] = 7'h20;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("in_reset");
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(instr_ready), 1);
        model_reset();

        // Single VADD: start pulse two cycles after handshake, done three cycles later
        drive(1, 7'h00, 5'd1, 5'd2, 5'd3, 25'd4);
        step();
        drive(0, 7'h00, 0, 0, 0, 0);
        step();
        chk("t1_start", 32'(vpu_start_op), 1);
        step();
        chk("t1_start_one_cycle", 32'(vpu_start_op), 0);
        step();
        step();
        done_pulse();
        chk("t1_retired", 32'(retired_count), 1);
        chk("t1_busy", 32'(busy), 0);

        // Five back-to-back with done withheld; queue fills, then FIFO-order drain
        base = m_ret;
        for (int i = 0; i < 5; i++) begin
            drive(1, lf[i], 5'(i + 4), 5'(i + 10), 5'(i + 20), 25'(100 + i));
            step();
        end
        drive(0, 7'h00, 0, 0, 0, 0);
        chk("b2b_qcount", 32'(queue_count), 4);
        chk("b2b_ready", 32'(instr_ready), 0);
        for (int i = 0; i < 5; i++) begin
            run_until_wait("b2b_reach_wait");
            chk("b2b_order_vl", 32'(vpu_vl), 32'(100 + i));
            done_pulse();
        end
        step();
        chk("b2b_retired", 32'(retired_count), 32'(base + 5));

        // Illegal funct
        drive(1, 7'b0000111, 5'd1, 5'd1, 5'd1, 25'd8);
        step();
        drive(0, 7'h00, 0, 0, 0, 0);
        chk("illegal_pulse", 32'(illegal_op), 1);
        chk("illegal_qcount", 32'(queue_count), 0);
        step();
        chk("illegal_one_cycle", 32'(illegal_op), 0);
        step();

        // Zero-length VSE retires without issue
        base = m_ret;
        drive(1, 7'h20, 5'd7, 5'd8, 5'd9, 25'd0);
        step();
        drive(0, 7'h00, 0, 0, 0, 0);
        step();
        step();
        chk("vl0_retired", 32'(retired_count), 32'(base + 1));
        chk("vl0_busy", 32'(busy), 0);

        // Watchdog: VLE never completes, queued VADD still issues afterwards
        drive(1, 7'h40, 5'd3, 5'd4, 5'd5, 25'd9);
        step();
        drive(1, 7'h00, 5'd6, 5'd7, 5'd8, 25'd12);
        step();
        drive(0, 7'h00, 0, 0, 0, 0);
        n = 0;
        while (!m_to && n < TO + 10) begin
            step();
            n++;
        end
        chk("timeout_flag", 32'(timeout_err), 1);
        chk("timeout_idle", 32'(vpu_enable), 0);
        run_until_wait("after_timeout_issue");
        chk("after_timeout_vl", 32'(vpu_vl), 12);
        done_pulse();
        step();

        // Flush during WAIT of the first of three
        base = m_ret;
        for (int i = 0; i < 3; i++) begin
            drive(1, lf[i], 5'(i), 5'(i + 1), 5'(i + 2), 25'(50 + i));
            step();
        end
        drive(0, 7'h00, 0, 0, 0, 0);
        run_until_wait("flush_reach_wait");
        flush = 1'b1;
        drive(1, 7'h01, 5'd1, 5'd1, 5'd1, 25'd1);
        step();
        flush = 1'b0;
        drive(0, 7'h00, 0, 0, 0, 0);
        chk("flush_qcount", 32'(queue_count), 0);
        chk("flush_no_illegal", 32'(illegal_op), 0);
        done_pulse();
        repeat (4) step();
        chk("flush_retired", 32'(retired_count), 32'(base + 1));

        // Random traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            sel = $urandom_range(0, 7);
            drive($urandom_range(0, 1) == 1,
                  (sel < 5) ? lf[sel] : 7'($urandom),
                  5'($urandom), 5'($urandom), 5'($urandom),
                  ($urandom_range(0, 4) == 0) ? 25'd0 : 25'($urandom));
            flush = ($urandom_range(0, 29) == 0);
            vpu_op_done = (ph == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            step();
        end
        drive(0, 7'h00, 0, 0, 0, 0);
        flush = 1'b0;
        vpu_op_done = 1'b0;
        repeat (3) step();

        // Reset mid-WAIT; later done ignored
        drive(1, 7'h02, 5'd9, 5'd9, 5'd9, 25'd33);
        step();
        drive(0, 7'h00, 0, 0, 0, 0);
        run_until_wait("rst_reach_wait");
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_pulse();
        step();
        chk("rst_done_ignored", 32'(retired_count), 0);
        chk("rst_idle", 32'(vpu_enable), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vector_issue_sequencer.md
Name: vector_issue_sequencer

Overview:
- Front-end controller for the vector execution unit.
- Accepts vector instructions from the scalar core through a valid/ready port and buffers them in a small in-order queue.
- Issues one instruction at a time to the vector unit using its start_op/op_done protocol.
- Drops illegal functs, retires zero-length ops locally, counts retirements and flags a hung unit with a watchdog.

Parameters:
- QUEUE_DEPTH, 4, instruction queue entries (power of two, >=2)
- VL_WIDTH, 25, vector-length field width; matches the vector unit vl port
- TIMEOUT_CYCLES, 64, max cycles in WAIT before watchdog fires
- CNT_WIDTH, 16, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  core presents an instruction
- instr_ready  out  1  queue can accept
- instr_funct  in  7  operation code
- instr_vs1  in  5  source register 1
- instr_vs2  in  5  source register 2
- instr_vr  in  5  destination register
- instr_vl  in  VL_WIDTH  requested vector length
- flush  in  1  synchronous; discards queued, not-yet-issued entries
- vpu_enable  out  1  vector unit enable
- vpu_start_op  out  1  one-cycle start pulse
- vpu_funct  out  7  issued funct
- vpu_vs1  out  5  issued source register 1
- vpu_vs2  out  5  issued source register 2
- vpu_vr  out  5  issued destination register
- vpu_vl  out  VL_WIDTH  issued vector length
- vpu_op_done  in  1  vector unit completion pulse
- busy  out  1  queue non-empty or FSM not IDLE
- queue_count  out  clog2(QUEUE_DEPTH+1)  current occupancy
- retired_count  out  CNT_WIDTH  retired instructions, wraps
- illegal_op  out  1  one-cycle pulse when an illegal funct is dropped
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: all outputs 0, queue empty, FSM IDLE. instr_ready goes 1 in the first cycle after rst deasserts.
- Legal functs: VADD 0000000, VSUB 0000001, VMUL 0000010, VLE 1000000, VSE 0100000.
- Enqueue:
  - Handshake is instr_valid && instr_ready; instr_ready = !full.
  - A push is not allowed when full, even if a pop happens in the same cycle.
- Illegal funct at handshake: not enqueued; illegal_op=1 in the next cycle only; instr_ready unaffected.
- vl: stored as given; the vector unit clamps it to its own length.
- Simultaneous push and pop on a non-empty queue: count unchanged, FIFO order preserved.
- flush: empties the queue on the same edge and has priority over a same-cycle push (push dropped, no illegal_op). An in-flight op continues to completion.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if the queue is non-empty, pop the head into the issue registers.
    - Head vl==0: retired_count+1, stay IDLE, no issue.
    - Otherwise go to ISSUE.
  - ISSUE: vpu_start_op=1 and vpu_enable=1 for exactly this cycle; vpu_funct/vs1/vs2/vr/vl hold the issue registers. Next state WAIT, watchdog cleared.
  - WAIT: vpu_enable held 1, vpu_start_op 0.
    - On vpu_op_done: retired_count+1, go IDLE.
    - Watchdog reaching TIMEOUT_CYCLES-1 with no done: timeout_err<=1 (sticky until rst), op not counted, go IDLE.
  - vpu_op_done outside WAIT is ignored.
- Latency, empty queue, FSM IDLE:
  - Push at edge E0 → pop at E1 → vpu_start_op high in the cycle after E1.
  - Next issue follows op_done by 2 cycles (IDLE, then ISSUE).
- vpu_* fields hold their last issued values between ops; they are 0 after reset.
- busy = (queue_count!=0) || state!=IDLE.
- rst mid-operation: queue, counters and flags cleared immediately; an in-flight op is abandoned and its later op_done is ignored.

Decomposition:
- Shared package vec_pkg: funct constants (VADD, VSUB, VMUL, VLE, VSE), FSM state encoding (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10), and an is_legal_funct function.
- Sub-module vec_instr_fifo: parameterised synchronous FIFO with push/pop/flush, full/empty, count, and a 7+15+VL_WIDTH-bit payload.

Test Plan:
- Push VADD vs1=1 vs2=2 vr=3 vl=4 → vpu_start_op high exactly 1 cycle, 2 cycles after handshake; op_done returned 3 cycles later → retired_count=1, busy=0.
- Push 5 ops back-to-back with vpu_op_done withheld → instr_ready=0 after the 5th accept attempt (queue_count=4, plus 1 in flight); release done pulses → issues in FIFO order, retired_count=5.
- Push funct=7'b0000111 → illegal_op pulses once, queue_count stays 0, no vpu_start_op.
- Push VSE vl=0 → no vpu_start_op, retired_count increments, busy returns 0 within 2 cycles.
- Issue VLE and never return op_done → timeout_err=1 after 64 WAIT cycles, FSM IDLE, the next queued op issues normally.
- Queue 3 ops, assert flush during WAIT of the first → queue_count=0 next cycle; first op completes, retired_count=1, nothing else issued.
- Assert rst during WAIT → all outputs 0 asynchronously; a later op_done is ignored and retired_count stays 0.
